dff_pipe: RTL and testbench
===========================

DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into every stage on reset or flush.
REQ-004 Port clk  input  1  single clock, all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk only).
REQ-006 Port en  input  1  shift enable; 0 = hold all stages.
REQ-007 Port flush  input  1  synchronous clear of all stages and valid bits.
REQ-008 Port d  input  WIDTH  data into stage 0.
REQ-009 Port d_valid  input  1  valid qualifier for d.
REQ-010 Port tap_sel  input  TAPW  stage index for tap output; TAPW = max(1, clog2(DEPTH)).
REQ-011 Port q  output  WIDTH  data of stage DEPTH-1.
REQ-012 Port q_valid  output  1  valid bit of stage DEPTH-1.
REQ-013 Port tap_q  output  WIDTH  data of stage tap_sel.
REQ-014 Port tap_valid  output  1  valid bit of stage tap_sel.
REQ-015 Port occupancy  output  OCCW  count of valid stages; OCCW = clog2(DEPTH+1).

Function
REQ-016 Stage i holds data[i] (WIDTH bits) and valid[i] (1 bit), i = 0..DEPTH-1.
REQ-017 Edge priority: reset low > flush high > en high > hold.
REQ-018 en=1, flush=0: stage0 <= {d, d_valid}; stage i <= stage i-1 for i>=1; contents of stage DEPTH-1 discarded.
REQ-019 en=0, flush=0: all stages hold; d and d_valid ignored.
REQ-020 flush=1: every data[i] <= RESET_VAL, every valid[i] <= 0, regardless of en; d in that cycle dropped.
REQ-021 Latency: with en held 1, d sampled at edge N appears on q after edge N+DEPTH-1 (DEPTH edges including capture edge N).
REQ-022 Stalls extend latency by exactly the number of en=0 edges; no data lost or duplicated.
REQ-023 Data with d_valid=0 still shifts (bubble); q_valid=0 for that slot, q carries the shifted data unchanged.
REQ-024 q, q_valid, tap_q, tap_valid are combinational from stage registers only (no input-to-output path).
REQ-025 tap_sel >= DEPTH: tap_q = RESET_VAL, tap_valid = 0.
REQ-026 occupancy = popcount(valid[0..DEPTH-1]), range 0..DEPTH, combinational from valid bits.
REQ-027 DEPTH=1: single stage; q and tap_q (tap_sel=0) identical; latency 1 edge.

Reset
REQ-028 reset=0 at a rising edge: all data[i] <= RESET_VAL, all valid[i] <= 0, overriding flush and en.
REQ-029 After reset: q = RESET_VAL, q_valid = 0, tap_q = RESET_VAL, tap_valid = 0, occupancy = 0.
REQ-030 Reset asserted mid-stream discards all in-flight data; no partial shift occurs on that edge.
REQ-031 No asynchronous path from reset to any register.

Structure
REQ-032 Shared package dff_pipe_pkg holds default WIDTH/DEPTH constants and the TAPW/OCCW width functions.
REQ-033 One sub-module dff_stage (WIDTH data + valid bit, reset/flush/en priority per REQ-017) instantiated DEPTH times by generate loop.
REQ-034 Tap mux and popcount live in dff_pipe top level; no additional sub-modules.

Verification (WIDTH=8, DEPTH=4, RESET_VAL=0)
REQ-035 reset=0 two edges, then reset=1 -> q=0x00, q_valid=0, occupancy=0.
REQ-036 en=1, d_valid=1, d=0x11,0x22,0x33,0x44 on edges 1-4 -> q=0x11, q_valid=1 after edge 4, occupancy=4; q=0x22 after edge 5.
REQ-037 Fill with 0xA1..0xA4, en=0 for 3 edges -> q stays 0xA1, occupancy stays 4; en=1 resumes, q=0xA2 next edge.
REQ-038 Full pipe, flush=1 and en=1 same edge with d=0xFF -> all stages 0x00, occupancy=0, 0xFF never appears on q.
REQ-039 Full pipe 0x11..0x44, tap_sel=0..3 -> tap_q=0x44,0x33,0x22,0x11 with tap_valid=1; DEPTH=3 build, tap_sel=3 -> tap_q=0x00, tap_valid=0.
REQ-040 Stream 0x55 (valid), 0x66 (d_valid=0), 0x77 (valid) then reset=0 with flush=1 at edge 3 -> occupancy=0 after edge 3; bubble case without reset gives q_valid sequence 1,0,1.

Source files
------------

// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg
// Shared constants and width helpers for the dff_pipe register pipeline.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default data width and stage count
//   tap_w(depth)                  : width of the tap_sel index, max(1, clog2(depth))
//   occ_w(depth)                  : width of the occupancy count, clog2(depth+1)
package dff_pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // A single-stage pipe still needs a 1-bit tap index.
    function automatic int tap_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // Must be able to represent the full count 0..depth.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_stage.sv
// dff_stage
// One pipeline stage: WIDTH data bits plus a valid bit.
// Update priority on the rising clock edge: reset low > flush high > en high > hold.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-low reset
//   flush    : synchronous clear to RESET_VAL / invalid
//   en       : load d/d_valid when high, hold when low
//   d        : data from the previous stage (or the pipe input)
//   d_valid  : valid bit from the previous stage (or the pipe input)
//   q        : registered data
//   q_valid  : registered valid bit
module dff_stage
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q       <= RESET_VAL;
            q_valid <= 1'b0;
        end else if (flush) begin
            q       <= RESET_VAL;
            q_valid <= 1'b0;
        end else if (en) begin
            q       <= d;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe
// DEPTH-stage shift pipeline of WIDTH-bit data with a per-stage valid bit,
// a selectable tap output and a count of occupied (valid) stages.
//
// Flow control: d_valid is a qualifier only. There is no ready; the pipe
// advances on every edge where en=1 (and flush=0, reset=1), whether or not
// d_valid is set, so an invalid slot travels through as a bubble carrying
// its data unchanged. With en=0 the input is ignored and nothing moves.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-low reset
//   en         : shift enable
//   flush      : synchronous clear of all stages
//   d, d_valid : input into stage 0
//   tap_sel    : stage index for tap_q/tap_valid
//   q, q_valid : last stage (DEPTH-1)
//   tap_q      : data of stage tap_sel (RESET_VAL when out of range)
//   tap_valid  : valid of stage tap_sel (0 when out of range)
//   occupancy  : number of valid stages
// All outputs are decoded from stage registers only.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              TAPW      = tap_w(DEPTH),
    localparam int              OCCW      = occ_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic [TAPW-1:0]  tap_sel,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [WIDTH-1:0] tap_q,
    output logic             tap_valid,
    output logic [OCCW-1:0]  occupancy
);

    logic [WIDTH-1:0] data     [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] in_data  [DEPTH];
    logic [DEPTH-1:0] in_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign in_data[i]  = d;
            assign in_valid[i] = d_valid;
        end else begin : g_link
            assign in_data[i]  = data[i-1];
            assign in_valid[i] = valid[i-1];
        end

        dff_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .en      (en),
            .d       (in_data[i]),
            .d_valid (in_valid[i]),
            .q       (data[i]),
            .q_valid (valid[i])
        );
    end

    assign q       = data[DEPTH-1];
    assign q_valid = valid[DEPTH-1];

    // tap_sel can exceed DEPTH-1 when DEPTH is not a power of two; such
    // indices fall through to the reset value / invalid.
    always_comb begin
        tap_q     = RESET_VAL;
        tap_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(tap_sel) == i) begin
                tap_q     = data[i];
                tap_valid = valid[i];
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCCW'(valid[i]);
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe
// Drives a DEPTH=4 and a DEPTH=3 dff_pipe from the same stimulus and compares
// every output with a queue-based model of the pipeline contents.
module tb_dff_pipe;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       flush;
    logic [7:0] d;
    logic       d_valid;
    logic [1:0] tap_sel;

    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic [7:0] q4, tap_q4;
    logic       q_valid4, tap_valid4;
    logic [2:0] occ4;
    logic [7:0] q3, tap_q3;
    logic       q_valid3, tap_valid3;
    logic [1:0] occ3;

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .d         (d),
        .d_valid   (d_valid),
        .tap_sel   (tap_sel),
        .q         (q4),
        .q_valid   (q_valid4),
        .tap_q     (tap_q4),
        .tap_valid (tap_valid4),
        .occupancy (occ4)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .d         (d),
        .d_valid   (d_valid),
        .tap_sel   (tap_sel),
        .q         (q3),
        .q_valid   (q_valid3),
        .tap_q     (tap_q3),
        .tap_valid (tap_valid3),
        .occupancy (occ3)
    );

    // ---------------- scoreboard ----------------
    // Each entry is {valid, data}; index 0 is stage 0.
    logic [8:0] exp_q[$];
    logic [8:0] exp3_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        exp_q  = {9'h0, 9'h0, 9'h0, 9'h0};
        exp3_q = {9'h0, 9'h0, 9'h0};
    endtask

    // Applies the edge rules to the model using the inputs present at the edge.
    task automatic model_edge();
        if (!reset || flush) begin
            model_clear();
        end else if (en) begin
            exp_q.push_front({d_valid, d});
            void'(exp_q.pop_back());
            exp3_q.push_front({d_valid, d});
            void'(exp3_q.pop_back());
        end
    endtask

    function automatic int count_valid(input logic [8:0] s[$]);
        int n = 0;
        foreach (s[i]) n += int'(s[i][8]);
        return n;
    endfunction

    task automatic check_model(input string tag);
        logic [8:0] t4, t3;
        t4 = (int'(tap_sel) < 4) ? exp_q[tap_sel]  : 9'h000;
        t3 = (int'(tap_sel) < 3) ? exp3_q[tap_sel] : 9'h000;
        check_eq({tag, ".q4"},     32'(q4),         32'(exp_q[3][7:0]));
        check_eq({tag, ".qv4"},    32'(q_valid4),   32'(exp_q[3][8]));
        check_eq({tag, ".tap4"},   32'(tap_q4),     32'(t4[7:0]));
        check_eq({tag, ".tapv4"},  32'(tap_valid4), 32'(t4[8]));
        check_eq({tag, ".occ4"},   32'(occ4),       32'(count_valid(exp_q)));
        check_eq({tag, ".q3"},     32'(q3),         32'(exp3_q[2][7:0]));
        check_eq({tag, ".qv3"},    32'(q_valid3),   32'(exp3_q[2][8]));
        check_eq({tag, ".tap3"},   32'(tap_q3),     32'(t3[7:0]));
        check_eq({tag, ".tapv3"},  32'(tap_valid3), 32'(t3[8]));
        check_eq({tag, ".occ3"},   32'(occ3),       32'(count_valid(exp3_q)));
    endtask

    // ---------------- driver tasks ----------------
    // One rising edge: model follows the inputs sampled at the edge, outputs
    // are checked 1ns later, away from the edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic drive(input logic r, input logic e, input logic f,
                         input logic [7:0] dd, input logic dv);
        reset   = r;
        en      = e;
        flush   = f;
        d       = dd;
        d_valid = dv;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] v;
        model_clear();
        tap_sel = 2'd0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // reset for two edges
        tick("rst0");
        tick("rst1");
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        check_eq("rst.q",   32'(q4),       32'h00);
        check_eq("rst.qv",  32'(q_valid4), 32'h0);
        check_eq("rst.occ", 32'(occ4),     32'h0);
        check_eq("rst.tap", 32'(tap_q4),   32'h00);

        // latency: 0x11..0x44 on four edges
        for (int i = 1; i <= 4; i++) begin
            v = 8'(i * 8'h11);
            drive(1'b1, 1'b1, 1'b0, v, 1'b1);
            tick("fill");
        end
        check_eq("lat.q",   32'(q4),       32'h11);
        check_eq("lat.qv",  32'(q_valid4), 32'h1);
        check_eq("lat.occ", 32'(occ4),     32'h4);

        // taps on a full pipe, held
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tap_sel = 2'(i);
            #1;
            v = 8'((4 - i) * 8'h11);
            check_eq("tap.q4",  32'(tap_q4),     32'(v));
            check_eq("tap.v4",  32'(tap_valid4), 32'h1);
        end
        // DEPTH=3 build, tap_sel=3 is out of range
        check_eq("tap3.oor.q", 32'(tap_q3),     32'h00);
        check_eq("tap3.oor.v", 32'(tap_valid3), 32'h0);
        tap_sel = 2'd0;

        drive(1'b1, 1'b1, 1'b0, 8'h55, 1'b1);
        tick("lat5");
        check_eq("lat5.q", 32'(q4), 32'h22);

        // stall: fill 0xA1..0xA4, hold 3 edges, resume
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'(8'hA0 + i), 1'b1);
            tick("fillA");
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            tick("stall");
            check_eq("stall.q",   32'(q4),   32'hA1);
            check_eq("stall.occ", 32'(occ4), 32'h4);
        end
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        tick("resume");
        check_eq("resume.q", 32'(q4), 32'hA2);

        // flush beats en; 0xFF is dropped
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);
        tick("flush");
        check_eq("flush.occ", 32'(occ4), 32'h0);
        check_eq("flush.q",   32'(q4),   32'h00);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
            tick("post_flush");
            check_eq("post_flush.q", 32'(q4), 32'h00);
        end

        // reset overrides flush mid-stream
        drive(1'b1, 1'b1, 1'b0, 8'h55, 1'b1); tick("s1");
        drive(1'b1, 1'b1, 1'b0, 8'h66, 1'b0); tick("s2");
        drive(1'b0, 1'b1, 1'b1, 8'h77, 1'b1); tick("s3_rst");
        check_eq("midrst.occ", 32'(occ4), 32'h0);
        check_eq("midrst.q",   32'(q4),   32'h00);

        // bubble passes through: q_valid 1,0,1 with data carried
        drive(1'b1, 1'b1, 1'b0, 8'h55, 1'b1); tick("b1");
        drive(1'b1, 1'b1, 1'b0, 8'h66, 1'b0); tick("b2");
        drive(1'b1, 1'b1, 1'b0, 8'h77, 1'b1); tick("b3");
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0); tick("b4");
        check_eq("bub1.qv", 32'(q_valid4), 32'h1);
        check_eq("bub1.q",  32'(q4),       32'h55);
        tick("b5");
        check_eq("bub2.qv", 32'(q_valid4), 32'h0);
        check_eq("bub2.q",  32'(q4),       32'h66);
        tick("b6");
        check_eq("bub3.qv", 32'(q_valid4), 32'h1);
        check_eq("bub3.q",  32'(q4),       32'h77);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 31) != 0),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 15) == 0),
                  8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
            tap_sel = 2'($urandom_range(0, 3));
            tick("rand");
        end

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
